cacheline_adapter: RTL
======================

# cacheline_adapter

Sits directly downstream of the cache's dfp port and bridges 256-bit cacheline transfers to a 64-bit burst memory. Each line read or write-back becomes one 4-beat burst. The adapter buffers the line, sequences the beats and returns a single-cycle dfp_resp to the cache. It holds exactly one transaction in flight.

## Interface
- Parameters: none. Line width is fixed at 256 bits, beat width at 64 bits, and every burst is 4 beats.
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- dfp_addr  in  32  line address from the cache; bits [4:0] are ignored and treated as 0.
- dfp_read  in  1  line read request; held stable by the cache until dfp_resp.
- dfp_write  in  1  line write request; held stable by the cache until dfp_resp.
- dfp_wdata  in  256  line to write; beat k is bits [64k+63:64k].
- dfp_rdata  out  256  returned line; valid while dfp_resp is high and held until the next read completes.
- dfp_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  32  burst address, always 32-byte aligned.
- bmem_read  out  1  read burst request.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  64  write beat data.
- bmem_ready  in  1  memory can accept a request or first write beat.
- bmem_raddr  in  32  address tag of the returned read beat.
- bmem_rdata  in  64  read beat data.
- bmem_rvalid  in  1  read beat valid.

## Operation
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, DONE. A 2-bit beat counter `cnt` tracks beat position. A 256-bit line buffer `buf` and a 27-bit line address register `laddr` are captured in IDLE.
- IDLE
  - dfp_write=1: capture laddr and buf←dfp_wdata, cnt←0, go to WR_DATA.
  - Else dfp_read=1: capture laddr, cnt←0, go to RD_REQ.
  - dfp_read and dfp_write both high is illegal; the write is serviced.
- RD_REQ
  - bmem_read=1, bmem_addr={laddr,5'b0}.
  - Stay until bmem_ready=1 at a rising edge, then go to RD_DATA.
- RD_DATA
  - Outputs: bmem_read=0.
  - On each edge with bmem_rvalid=1 and bmem_raddr[31:5]==laddr: buf[64·cnt +:64]←bmem_rdata, cnt←cnt+1.
  - A beat with a mismatched raddr is dropped.
  - When the accepted beat has cnt==3, go to DONE. Beats need not be consecutive.
- WR_DATA
  - bmem_write=1, bmem_addr={laddr,5'b0}, bmem_wdata=buf[64·cnt +:64].
  - Beat 0 advances only on an edge with bmem_ready=1.
  - Beats 1–3 advance unconditionally, one per cycle; the memory guarantees acceptance once beat 0 is taken.
  - After beat 3 go to DONE.
- DONE
  - dfp_resp=1 and dfp_rdata=buf; go to IDLE the next edge.
  - The cache has seen resp by then, so IDLE never re-captures the same request.
- Output defaults
  - bmem_read, bmem_write and dfp_resp are 0 outside the states listed above.
  - bmem_addr and bmem_wdata are 0 in IDLE.
- bmem_rvalid outside RD_DATA is ignored.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE and cnt to 0.
  - Outputs: bmem_read, bmem_write, dfp_resp, bmem_addr, bmem_wdata are 0, and dfp_rdata/buf are 0.
  - Reset mid-burst aborts the burst immediately, with no dfp_resp. Beats already in flight after release arrive in IDLE and are ignored.
- Read latency: request seen at edge 0. bmem_read is high from cycle 1 until the edge where ready is sampled. dfp_resp is high the cycle after the edge that accepts beat 3. The minimum is 6 cycles, with ready=1 and beats on cycles 2–5.
- Write latency: beats occupy cycles 1–4 when ready=1 at cycle 1. dfp_resp is high in cycle 5.
- Each ready=0 cycle at beat 0 adds one cycle.
- One dfp_resp per request; never two in consecutive cycles.

## Test plan
- Reset hold of 4 cycles with random bmem inputs → all outputs 0, and no bmem_read or bmem_write after release while the dfp inputs are idle.
- Read at dfp_addr=0x0000_0207, ready=1, beats 0x11..11/0x22..22/0x33..33/0x44..44 on consecutive cycles:
  - bmem_addr=0x200 for exactly 1 cycle.
  - dfp_resp pulses 1 cycle, 6 cycles after the request.
  - dfp_rdata={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write of line 0xDDDD..CCCC..BBBB..AAAA (beat 0 = 0xAAAA_AAAA_AAAA_AAAA) at 0x400, ready=0 for 3 cycles then 1:
  - bmem_wdata beat 0 is held during the stall, then 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.. on 4 consecutive cycles.
  - dfp_resp follows 1 cycle later.
- Read at 0x600 with rvalid gaps of 0, 2, 1 idle cycles between beats, plus one stray beat with raddr=0x800 → stray beat not stored, correct 4-beat line returned, dfp_resp once.
- Reset asserted after beat 1 of a read at 0x200, then a new read at 0x400 → no dfp_resp for 0x200; the 0x400 line completes normally and leftover 0x200 beats are ignored.
- Back-to-back: read 0x000, then write 0x000 requested in the cycle after dfp_resp → second burst starts within 1 cycle, with no overlap of bmem_read and bmem_write.

Source files
------------

// File: rtl/cacheline_adapter.sv
// Bridges 256-bit cacheline reads/write-backs from the cache dfp port to a
// 64-bit, 4-beat burst memory, one transaction in flight at a time.
module cacheline_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  dfp_addr,
  input  logic         dfp_read,
  input  logic         dfp_write,
  input  logic [255:0] dfp_wdata,
  output logic [255:0] dfp_rdata,
  output logic         dfp_resp,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [31:0]  bmem_raddr,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid
);

  typedef enum logic [2:0] {StIdle, StRdReq, StRdData, StWrData, StDone} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [26:0]   laddr_q, laddr_d;
  logic [255:0]  line_q, line_d;
  logic [255:0]  rdata_q, rdata_d;
  logic          beat_hit;
  logic          unused;

  // Low address bits carry no information for line-aligned traffic.
  assign unused = ^{dfp_addr[4:0], bmem_raddr[4:0]};

  assign beat_hit = bmem_rvalid && (bmem_raddr[31:5] == laddr_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      laddr_q <= 27'd0;
      line_q  <= 256'd0;
      rdata_q <= 256'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      laddr_q <= laddr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    laddr_d = laddr_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        // A simultaneous read and write is illegal; the write wins.
        if (dfp_write) begin
          laddr_d = dfp_addr[31:5];
          line_d  = dfp_wdata;
          cnt_d   = 2'd0;
          state_d = StWrData;
        end else if (dfp_read) begin
          laddr_d = dfp_addr[31:5];
          cnt_d   = 2'd0;
          state_d = StRdReq;
        end
      end
      StRdReq: begin
        if (bmem_ready) state_d = StRdData;
      end
      StRdData: begin
        if (beat_hit) begin
          line_d[{cnt_q, 6'd0} +: 64] = bmem_rdata;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // Returned line is kept separately so write-backs never disturb it.
            rdata_d = {bmem_rdata, line_q[191:0]};
            state_d = StDone;
          end
        end
      end
      StWrData: begin
        // Only beat 0 waits on ready; the memory takes the rest back to back.
        if (cnt_q != 2'd0 || bmem_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = 32'd0;
    bmem_wdata = 64'd0;
    dfp_resp   = 1'b0;
    dfp_rdata  = rdata_q;
    unique case (state_q)
      StRdReq: begin
        bmem_read = 1'b1;
        bmem_addr = {laddr_q, 5'd0};
      end
      StWrData: begin
        bmem_write = 1'b1;
        bmem_addr  = {laddr_q, 5'd0};
        bmem_wdata = line_q[{cnt_q, 6'd0} +: 64];
      end
      StDone: begin
        dfp_resp = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
